// File: rtl/apb_regs_bist.sv
// apb_regs_bist: APB master running a write/read-back register test
//   Purpose : for each pattern (0, 1s, 55.., AA..) and each register, write the
//             pattern and read it back. Bits outside the register's writable
//             mask are ignored. PSLVERR responses and readback mismatches are
//             counted, and the first failure is captured.
//   Latency : start sampled at edge k, first SETUP in cycle k+1; each transfer
//             takes 2+w cycles; done pulses in the cycle after the last ACCESS.
//   Backpressure: pready=0 extends ACCESS; after TIMEOUT ACCESS cycles the test
//             aborts and reports timeout.
// Ports:
//   pclk, prst        clock, synchronous active-high reset
//   start, reg_mask   test trigger (sampled only when idle), per-register writable bits
//   busy, done, pass, timeout, err_cnt, first_err_addr, first_err_data   status
//   paddr, psel, penable, pwrite, pwdata, pstrb, pready, prdata, pslverr APB master
module apb_regs_bist #(
  parameter int                APB_AW    = 32,
  parameter int                APB_DW    = 32,
  parameter logic [APB_AW-1:0] BASE_ADDR = '0,
  parameter int                REG_QTY   = 8,
  parameter int                TIMEOUT   = 16,
  parameter int                ERR_W     = 8
) (
  input  logic                      pclk,
  input  logic                      prst,
  input  logic                      start,
  input  logic [REG_QTY*APB_DW-1:0] reg_mask,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout,
  output logic [ERR_W-1:0]          err_cnt,
  output logic [APB_AW-1:0]         first_err_addr,
  output logic [APB_DW-1:0]         first_err_data,
  output logic [APB_AW-1:0]         paddr,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [APB_DW-1:0]         pwdata,
  output logic [APB_DW/8-1:0]       pstrb,
  input  logic                      pready,
  input  logic [APB_DW-1:0]         prdata,
  input  logic                      pslverr
);

  localparam int               BYTES    = APB_DW / 8;
  localparam int               REG_W    = (REG_QTY > 1) ? $clog2(REG_QTY) : 1;
  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [REG_W-1:0] REG_LAST = REG_W'(REG_QTY - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       pat_idx, pat_idx_nxt;
  logic [REG_W-1:0] reg_idx, reg_idx_nxt;
  logic             rd_phase, rd_phase_nxt;
  logic [CNT_W-1:0] wait_cnt;

  logic              launch;     // leaving IDLE: reset indices and results
  logic              step;       // current transfer completed (pready seen)
  logic              abort;      // current transfer timed out
  logic              last_xfer;
  logic              load_xfer;  // latch address/data/direction for next SETUP
  logic              err_hit;
  logic [APB_DW-1:0] pat_cur;
  logic [APB_DW-1:0] mask_cur;
  logic [ERR_W-1:0]  err_cnt_nxt;

  function automatic logic [APB_DW-1:0] pattern(input logic [1:0] idx);
    logic [APB_DW-1:0] p;
    case (idx)
      2'd0:    p = '0;
      2'd1:    p = '1;
      2'd2:    p = {BYTES{8'h55}};
      default: p = {BYTES{8'hAA}};
    endcase
    return p;
  endfunction

  function automatic logic [APB_AW-1:0] reg_addr(input logic [REG_W-1:0] idx);
    return BASE_ADDR + APB_AW'(idx) * APB_AW'(BYTES);
  endfunction

  assign pat_cur   = pattern(pat_idx);
  assign mask_cur  = reg_mask[int'(reg_idx)*APB_DW +: APB_DW];
  assign last_xfer = (pat_idx == 2'd3) && (reg_idx == REG_LAST) && rd_phase;

  // APB control decodes straight from the state register, so psel/penable
  // drop in the cycle after an abort or reset.
  assign psel    = (state == SETUP) || (state == ACCESS);
  assign penable = (state == ACCESS);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign pstrb   = '1;

  always_ff @(posedge pclk) begin
    if (prst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    step      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          launch    = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        // A response in the last allowed ACCESS cycle still counts.
        if (pready) begin
          step      = 1'b1;
          state_nxt = last_xfer ? DONE : SETUP;
        end else if (wait_cnt == CNT_LAST) begin
          abort     = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sequence order: write then read per register, registers inner, patterns outer.
  always_comb begin
    pat_idx_nxt  = pat_idx;
    reg_idx_nxt  = reg_idx;
    rd_phase_nxt = rd_phase;
    if (launch) begin
      pat_idx_nxt  = 2'd0;
      reg_idx_nxt  = '0;
      rd_phase_nxt = 1'b0;
    end else if (step) begin
      if (!rd_phase) begin
        rd_phase_nxt = 1'b1;
      end else begin
        rd_phase_nxt = 1'b0;
        if (reg_idx == REG_LAST) begin
          reg_idx_nxt = '0;
          pat_idx_nxt = pat_idx + 2'd1;
        end else begin
          reg_idx_nxt = reg_idx + 1'b1;
        end
      end
    end
  end

  assign load_xfer   = launch || (step && !last_xfer);
  assign err_hit     = step && (pslverr || (rd_phase && (|((prdata ^ pat_cur) & mask_cur))));
  assign err_cnt_nxt = (err_hit && (err_cnt != '1)) ? err_cnt + 1'b1 : err_cnt;

  always_ff @(posedge pclk) begin
    if (prst) begin
      pat_idx        <= 2'd0;
      reg_idx        <= '0;
      rd_phase       <= 1'b0;
      wait_cnt       <= '0;
      paddr          <= '0;
      pwrite         <= 1'b0;
      pwdata         <= '0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      pat_idx  <= pat_idx_nxt;
      reg_idx  <= reg_idx_nxt;
      rd_phase <= rd_phase_nxt;

      if (state == SETUP)                 wait_cnt <= '0;
      else if (state == ACCESS && !pready) wait_cnt <= wait_cnt + 1'b1;

      // Bus fields change only between transfers, keeping them stable
      // from SETUP through every wait cycle.
      if (load_xfer) begin
        paddr  <= reg_addr(reg_idx_nxt);
        pwrite <= !rd_phase_nxt;
        pwdata <= pattern(pat_idx_nxt);
      end

      if (launch) begin
        err_cnt        <= '0;
        first_err_addr <= '0;
        first_err_data <= '0;
        pass           <= 1'b0;
        timeout        <= 1'b0;
      end else begin
        err_cnt <= err_cnt_nxt;
        if (err_hit && (err_cnt == '0)) begin
          first_err_addr <= paddr;
          first_err_data <= rd_phase ? prdata : '0;
        end
        // Result is registered on entry to DONE so it is valid alongside done.
        if (abort) begin
          timeout <= 1'b1;
          pass    <= 1'b0;
        end else if (step && last_xfer) begin
          pass <= (err_cnt_nxt == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_regs_bist.sv
// tb_apb_regs_bist: directed and random register-test runs against a
// behavioural APB slave with configurable waits, stuck bits and error responses.
module tb_apb_regs_bist;

  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          Q    = 4;
  localparam int          TO   = 16;
  localparam int          EW   = 3;
  localparam int          NX   = 8 * Q;
  localparam logic [31:0] BASE = 32'h0000_0100;

  logic          pclk = 1'b0;
  logic          prst = 1'b1;
  logic          start = 1'b0;
  logic [Q*DW-1:0] reg_mask = '1;
  logic          busy, done, pass, timeout;
  logic [EW-1:0] err_cnt;
  logic [AW-1:0] first_err_addr, paddr;
  logic [DW-1:0] first_err_data, pwdata, prdata;
  logic          psel, penable, pwrite, pready, pslverr;
  logic [DW/8-1:0] pstrb;

  apb_regs_bist #(
    .APB_AW(AW), .APB_DW(DW), .BASE_ADDR(BASE),
    .REG_QTY(Q), .TIMEOUT(TO), .ERR_W(EW)
  ) dut (
    .pclk(pclk), .prst(prst), .start(start), .reg_mask(reg_mask),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_cnt(err_cnt), .first_err_addr(first_err_addr), .first_err_data(first_err_data),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  // ---------------- slave configuration (indexed by transfer / register)
  int          ws_a   [NX];  // wait states of transfer t; >= TO means never ready
  bit          err_at [NX];  // PSLVERR on transfer t
  logic [31:0] s0     [Q];   // stuck-at-0 bits
  logic [31:0] s1     [Q];   // stuck-at-1 bits
  logic [31:0] mask_a [Q];
  logic [31:0] pats   [4] = '{32'h0, 32'hFFFF_FFFF, 32'h5555_5555, 32'hAAAA_AAAA};

  // ---------------- behavioural slave
  logic [31:0] mem [Q];
  int          wcnt, tidx;
  logic [1:0]  sidx;

  always_comb begin
    sidx    = 2'((paddr - BASE) >> 2);
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    if (psel && penable && tidx < NX && wcnt >= ws_a[tidx]) begin
      pready  = 1'b1;
      pslverr = err_at[tidx];
    end
    if (psel && !pwrite) prdata = (mem[sidx] & ~s0[sidx]) | s1[sidx];
  end

  always @(posedge pclk) begin
    if (prst || (start && !busy)) begin
      wcnt <= 0;
      tidx <= 0;
    end else if (psel && penable) begin
      if (pready) begin
        wcnt <= 0;
        tidx <= tidx + 1;
        if (pwrite) mem[sidx] <= pwdata;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  // ---------------- bus monitor: transfer log, psel cycle count, stability
  logic [64:0] log_q[$];
  int          psel_cyc = 0;
  int          stab_err = 0;
  logic [64:0] cap;

  always @(negedge pclk) begin
    if (penable && !psel) stab_err++;
    if (psel) psel_cyc++;
    if (psel && !penable) cap = {pwrite, paddr, pwdata};
    else if (psel && penable && cap !== {pwrite, paddr, pwdata}) stab_err++;
    if (psel && penable && pready) log_q.push_back({pwrite, paddr, pwrite ? pwdata : 32'h0});
  end

  // ---------------- checking
  int    n_vec = 0;
  int    n_err = 0;
  string cur_name = "reset";

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s/%s: got %0h expected %0h", cur_name, tag, obs, expv);
    end
  endtask

  // ---------------- reference model: walks the test sequence abstractly
  int          exp_cnt, exp_psel;
  bit          exp_pass, exp_to;
  logic [31:0] exp_faddr, exp_fdata;
  logic [64:0] exp_log[$];

  task automatic model_run();
    int t = 0;
    bit found = 0;
    exp_cnt = 0; exp_psel = 0; exp_to = 0;
    exp_faddr = 0; exp_fdata = 0;
    exp_log.delete();
    for (int p = 0; p < 4; p++)
      for (int r = 0; r < Q; r++)
        for (int ph = 0; ph < 2; ph++) begin
          if (!exp_to) begin
            if (ws_a[t] >= TO) begin
              exp_psel += 1 + TO;
              exp_to = 1;
            end else begin
              logic [31:0] addr, rd;
              bit wr, bad;
              exp_psel += 2 + ws_a[t];
              wr   = (ph == 0);
              addr = BASE + 32'(r * 4);
              rd   = (pats[p] & ~s0[r]) | s1[r];
              exp_log.push_back({wr, addr, wr ? pats[p] : 32'h0});
              bad = err_at[t] || (!wr && ((rd ^ pats[p]) & mask_a[r]) != 0);
              if (bad) begin
                if (!found) begin
                  found = 1;
                  exp_faddr = addr;
                  exp_fdata = wr ? 32'h0 : rd;
                end
                if (exp_cnt < (1 << EW) - 1) exp_cnt++;
              end
            end
          end
          t++;
        end
    exp_pass = !exp_to && exp_cnt == 0;
  endtask

  task automatic clear_cfg();
    for (int t = 0; t < NX; t++) begin ws_a[t] = 0; err_at[t] = 0; end
    for (int r = 0; r < Q; r++) begin s0[r] = 0; s1[r] = 0; mask_a[r] = '1; end
  endtask

  task automatic rand_cfg();
    for (int t = 0; t < NX; t++) begin
      if ($urandom_range(0, 99) < 2) ws_a[t] = $urandom_range(0, 1) ? TO - 1 : TO + int'($urandom_range(0, 3));
      else                            ws_a[t] = $urandom_range(0, 3);
      err_at[t] = ($urandom_range(0, 29) == 0);
    end
    for (int r = 0; r < Q; r++) begin
      s0[r]     = ($urandom_range(0, 2) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
      s1[r]     = ($urandom_range(0, 2) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
      mask_a[r] = $urandom_range(0, 1) ? 32'hFFFF_FFFF : $urandom;
    end
  endtask

  // Called at a negedge; returns at the negedge after the DONE cycle.
  task automatic run_test(input string name, input int pulse_at, input bit hold);
    int c, nbusy, p0, l0, e0, n;
    bit seen;
    cur_name = name;
    for (int r = 0; r < Q; r++) reg_mask[r*DW +: DW] = mask_a[r];
    model_run();
    p0 = psel_cyc; l0 = log_q.size(); e0 = stab_err;
    start = 1'b1;
    @(posedge pclk); @(negedge pclk);
    c = 1;
    chk("setup_ctl", {busy, psel, penable, pwrite}, 4'b1101);
    chk("setup_addr", paddr, BASE);
    chk("setup_data", pwdata, 32'h0);
    if (!hold) start = 1'b0;
    nbusy = 0; seen = 0;
    while (c < 3000) begin
      if (busy) nbusy++;
      if (done) begin seen = 1; break; end
      @(negedge pclk); c++;
      if (pulse_at == c) start = 1'b1;
      else if (!hold)    start = 1'b0;
    end
    chk("done_seen", seen, 1'b1);
    chk("done_cycle", c, 1 + exp_psel);
    chk("busy_cycles", nbusy, exp_psel + 1);
    chk("done_psel", {psel, penable}, 2'b00);
    chk("pass", pass, exp_pass);
    chk("timeout", timeout, exp_to);
    chk("err_cnt", err_cnt, exp_cnt);
    chk("first_addr", first_err_addr, exp_faddr);
    chk("first_data", first_err_data, exp_fdata);
    @(negedge pclk);
    chk("after_done", {busy, done}, 2'b00);
    chk("pass_held", {pass, timeout, err_cnt}, {exp_pass, exp_to, EW'(exp_cnt)});
    chk("psel_cycles", psel_cyc - p0, exp_psel);
    chk("stable", stab_err - e0, 0);
    n = log_q.size() - l0;
    chk("log_len", n, exp_log.size());
    for (int i = 0; i < n && i < exp_log.size(); i++) chk("xfer", log_q[l0 + i], exp_log[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_cfg();
    repeat (3) @(negedge pclk);
    chk("rst_ctl", {psel, penable, busy, done, pass, timeout, pwrite}, 7'b0);
    chk("rst_err", err_cnt, 0);
    chk("rst_faddr", first_err_addr, 0);
    chk("rst_fdata", first_err_data, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_pstrb", pstrb, 4'hF);
    prst = 1'b0;
    @(negedge pclk);

    clear_cfg();                                   run_test("ideal", 0, 0);
    clear_cfg(); s0[2] = 32'h1;                     run_test("stuck_r2b0", 0, 0);
    clear_cfg(); s0[2] = 32'h1; mask_a[2] = 32'hFFFF_FFFE; run_test("masked", 0, 0);
    clear_cfg(); for (int t = 0; t < NX; t++) ws_a[t] = 3; run_test("wait3", 0, 0);
    clear_cfg(); ws_a[0] = TO;                      run_test("timeout_first", 0, 0);
    clear_cfg(); ws_a[5] = TO - 1; ws_a[9] = TO;    run_test("timeout_edge", 0, 0);
    clear_cfg(); err_at[2] = 1;                     run_test("slverr_wr_r1", 0, 0);
    clear_cfg(); err_at[7] = 1; s1[1] = 32'h8000_0000; run_test("slverr_rd", 0, 0);
    clear_cfg(); for (int r = 0; r < Q; r++) s0[r] = '1; run_test("saturate", 0, 0);
    clear_cfg(); ws_a[4] = 2;                       run_test("busy_pulse", 10, 0);
    clear_cfg();                                    run_test("hold_start", 0, 1);
    clear_cfg(); s1[3] = 32'h10;                    run_test("after_hold", 0, 0);

    // Reset in the middle of a transfer with one error already recorded.
    clear_cfg(); cur_name = "reset_mid";
    for (int t = 0; t < NX; t++) ws_a[t] = 2;
    s1[0] = 32'h1;
    start = 1'b1;
    @(posedge pclk); @(negedge pclk);
    start = 1'b0;
    repeat (9) @(negedge pclk);
    chk("pre_rst_err", err_cnt, 1);
    chk("pre_rst_data", first_err_data, 32'h1);
    chk("pre_rst_ctl", {psel, penable}, 2'b11);
    prst = 1'b1;
    @(negedge pclk);
    chk("rst_mid_ctl", {psel, penable, busy, done, pass, timeout}, 6'b0);
    chk("rst_mid_err", {err_cnt, first_err_addr, first_err_data}, 0);
    prst = 1'b0;
    begin
      int act = 0;
      repeat (4) begin @(negedge pclk); if (psel || penable) act++; end
      chk("rst_quiet", act, 0);
    end
    clear_cfg(); run_test("after_reset", 0, 0);

    for (int i = 0; i < 20; i++) begin
      clear_cfg(); rand_cfg();
      run_test($sformatf("rand%0d", i), 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
